// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: opcode encoding, fetch FSM states, instruction word layout.
// Used by fetch, control and datapath so that they all agree on the IR field slicing.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 5;
  localparam int CPU_OPC_W   = 3;
  localparam int CPU_DATA_W  = CPU_OPC_W + CPU_ADDR_W;
  localparam int CPU_TIMEOUT = 15;

  typedef enum logic [CPU_OPC_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd2,
    ADD = 3'd3,
    AND = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_HOLD,
    F_HALT
  } fetch_state_e;

  function automatic logic [CPU_OPC_W-1:0] ir_opcode(input logic [CPU_DATA_W-1:0] word);
    return word[CPU_DATA_W-1 -: CPU_OPC_W];
  endfunction

  function automatic logic [CPU_ADDR_W-1:0] ir_operand(input logic [CPU_DATA_W-1:0] word);
    return word[CPU_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: load beats increment, wraps modulo 2**ADDR_W, frozen while run is low.
// One-cycle update; no backpressure.
module pc_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (run) begin
      if (load) begin
        pc <= load_val;
      end else if (inc) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Owns PC and IR; fetches one word per instruction over imem req/ack with an ack timeout.
// IR valid 2 cycles after memIns_en with a 1-cycle memory; fetch_stall holds control while in flight.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int OPC_W   = CPU_OPC_W,
  parameter int DATA_W  = CPU_DATA_W,
  parameter int TIMEOUT = CPU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memIns_en,
  input  logic              pc_en,
  input  logic              pc_load,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              ir_valid,
  output logic              fetch_stall,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e      state;
  logic [DATA_W-1:0] ir;
  logic [CNT_W-1:0]  wait_cnt;
  logic              pc_run;

  assign pc_run = (state != F_HALT);

  pc_counter #(.ADDR_W(ADDR_W)) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .run      (pc_run),
    .load     (pc_load),
    .inc      (pc_en),
    .load_val (ir_addr),
    .pc       (pc)
  );

  // The fetch address is the PC register itself, so it is registered and always coherent with pc.
  assign imem_addr   = pc;
  assign opcode      = ir[DATA_W-1 -: OPC_W];
  assign ir_addr     = ir[ADDR_W-1:0];
  assign fetch_stall = (state == F_REQ) ||
                       ((state == F_IDLE) && memIns_en && !ir_valid && !halt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= F_IDLE;
      ir        <= '0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        F_IDLE: begin
          if (memIns_en && !halt && !ir_valid) begin
            state    <= F_REQ;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end
        end
        F_REQ: begin
          // halt wins over a coincident ack so a halted CPU never latches a new word
          if (halt) begin
            state    <= F_HALT;
            imem_req <= 1'b0;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= F_HOLD;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= F_HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        F_HOLD: begin
          if (halt) begin
            state <= F_HALT;
          end else if (pc_en || pc_load) begin
            ir_valid <= 1'b0;
            state    <= F_IDLE;
          end
        end
        F_HALT: begin
          imem_req <= 1'b0;
        end
        default: begin
          state    <= F_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
